slvx_burst_fifo: RTL and testbench

- Output stage directly downstream of the two-slave arbiter.
- Captures each arbitrated word (slvx_data plus its slvx_mode and slvx_proc_val tags) into a synchronous FIFO.
- Drives fifo_full back to the arbiter as back-pressure.
- Releases stored words to the memory-write master as fixed-length bursts over a valid/ready handshake. A flush request drains a partial final burst.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/sync_fifo_mem.sv | 73 +++++++
 rtl/slvx_burst_fifo.sv | 144 ++++++++++++++
 tb/tb_slvx_burst_fifo.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the arbiter output stage: word tags, stored entry layout, burst FSM states.
package arb_pkg;

  // Data width the arbiter is built for; slvx_entry_t is laid out at this width.
  localparam int unsigned SLVX_DW = 32;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } mode_t;

  // One stored word: tags in the upper bits, data in the lower bits.
  typedef struct packed {
    mode_t                mode;
    logic [7:0]           proc_val;
    logic [SLVX_DW-1:0]   data;
  } slvx_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } burst_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-pointer storage array with occupancy count, show-ahead read and sticky drop flag.
module sync_fifo_mem
  import arb_pkg::*;
#(
  parameter  int unsigned EW    = 42,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [EW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [EW-1:0] o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_overflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  // A pop in the same cycle frees a slot, so a push at full is still accepted then.
  assign w_full    = (r_count == DEPTH_C);
  assign w_do_pop  = i_pop & (r_count != ZERO_C);
  assign w_do_push = i_push & (~w_full | w_do_pop);

  assign o_rdata    = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= ZERO_C;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_push & ~w_do_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/slvx_burst_fifo.sv
// Arbiter output stage: buffers tagged words and releases them as fixed-length bursts,
// with a flush request that drains a short final burst.
module slvx_burst_fifo
  import arb_pkg::*;
#(
  parameter  int unsigned DW        = 32,
  parameter  int unsigned DEPTH     = 16,
  parameter  int unsigned BURST_LEN = 4,
  parameter  int unsigned AFULL     = 2,
  localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          slvx_data_valid,
  input  logic [1:0]    slvx_mode,
  input  logic [7:0]    slvx_proc_val,
  input  logic [DW-1:0] slvx_data,
  output logic          fifo_full,
  input  logic          flush,
  output logic          mst_valid,
  input  logic          mst_ready,
  output logic [DW-1:0] mst_data,
  output logic [1:0]    mst_mode,
  output logic [7:0]    mst_proc_val,
  output logic          mst_last,
  output logic          burst_done,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  // Entry layout matches slvx_entry_t ({mode, proc_val, data}) but follows DW.
  localparam int unsigned   EW      = DW + 10;
  localparam logic [CW-1:0] BURST_C = CW'(BURST_LEN);
  localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - AFULL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);

  burst_state_t  r_state;
  burst_state_t  w_state_nxt;
  logic [CW-1:0] r_beats;
  logic [CW-1:0] w_beats_nxt;
  logic          r_flush_pend;
  logic          w_flush_clr;
  logic          w_pop;
  logic [CW-1:0] w_count;
  logic [EW-1:0] w_wr_entry;
  logic [EW-1:0] w_head;

  assign w_wr_entry   = {slvx_mode, slvx_proc_val, slvx_data};
  assign w_pop        = mst_valid & mst_ready;
  assign mst_mode     = w_head[EW-1 -: 2];
  assign mst_proc_val = w_head[DW+7 -: 8];
  assign mst_data     = w_head[DW-1:0];
  assign fifo_count   = w_count;
  // Asserts AFULL entries early so words already in flight from the arbiter still fit.
  assign fifo_full    = (w_count >= FULL_TH);

  sync_fifo_mem #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (slvx_data_valid),
    .i_wdata    (w_wr_entry),
    .i_pop      (w_pop),
    .o_rdata    (w_head),
    .o_count    (w_count),
    .o_overflow (overflow)
  );

  // Burst state and remaining-beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_beats <= ZERO_C;
    end else begin
      r_state <= w_state_nxt;
      r_beats <= w_beats_nxt;
    end
  end

  // Pending flush: a new pulse wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flush_pend <= 1'b0;
    end else if (flush) begin
      r_flush_pend <= 1'b1;
    end else if (w_flush_clr) begin
      r_flush_pend <= 1'b0;
    end else begin
      r_flush_pend <= r_flush_pend;
    end
  end

  // Next-state and beat outputs; beats are reserved at entry, so count never underruns.
  always_comb begin
    w_state_nxt = r_state;
    w_beats_nxt = r_beats;
    w_flush_clr = 1'b0;
    mst_valid   = 1'b0;
    mst_last    = 1'b0;
    burst_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_count >= BURST_C) begin
          w_state_nxt = BURST;
          w_beats_nxt = BURST_C;
        end else if (r_flush_pend && (w_count != ZERO_C)) begin
          w_state_nxt = BURST;
          w_beats_nxt = w_count;
          w_flush_clr = 1'b1;
        end else if (w_count == ZERO_C) begin
          w_flush_clr = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BURST: begin
        mst_valid = 1'b1;
        mst_last  = (r_beats == ONE_C);
        if (mst_ready) begin
          w_beats_nxt = r_beats - ONE_C;
          if (r_beats == ONE_C) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = BURST;
          end
        end else begin
          w_state_nxt = BURST;
        end
      end
      DONE: begin
        burst_done  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_beats_nxt = ZERO_C;
      end
    endcase
  end

endmodule

// File: tb/tb_slvx_burst_fifo.sv
// Directed bench for slvx_burst_fifo: a small queue model tracks every accepted word.
module tb_slvx_burst_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        slvx_data_valid;
  logic [1:0]  slvx_mode;
  logic [7:0]  slvx_proc_val;
  logic [31:0] slvx_data;
  logic        flush;
  logic        mst_ready;
  logic        fifo_full;
  logic        mst_valid;
  logic [31:0] mst_data;
  logic [1:0]  mst_mode;
  logic [7:0]  mst_proc_val;
  logic        mst_last;
  logic        burst_done;
  logic [4:0]  fifo_count;
  logic        overflow;

  always #5 clk = ~clk;

  slvx_burst_fifo dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .slvx_data_valid (slvx_data_valid),
    .slvx_mode       (slvx_mode),
    .slvx_proc_val   (slvx_proc_val),
    .slvx_data       (slvx_data),
    .fifo_full       (fifo_full),
    .flush           (flush),
    .mst_valid       (mst_valid),
    .mst_ready       (mst_ready),
    .mst_data        (mst_data),
    .mst_mode        (mst_mode),
    .mst_proc_val    (mst_proc_val),
    .mst_last        (mst_last),
    .burst_done      (burst_done),
    .fifo_count      (fifo_count),
    .overflow        (overflow)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [41:0] exp_q[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          beat_total = 0;
  int          beat_idx = 0;
  int          last_idx = 0;
  int          last_cyc = 0;
  int          done_cyc = 0;
  int          stall_cmp = 0;
  logic        prev_stall = 1'b0;
  logic        prev_both = 1'b0;
  logic [42:0] prev_beat;
  logic [4:0]  prev_count;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stored entry for word number id: {mode, proc_val, data}
  function automatic logic [41:0] word(input int id);
    logic [31:0] d;
    logic [7:0]  pv;
    logic [1:0]  m;
    d  = 32'hA500_0000 + id;
    m  = id[1:0];
    pv = {id[3:0], ~id[3:0]};
    return {m, pv, d};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: model occupancy, beat order/content, stall stability, burst_done pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      beat_idx   = 0;
      prev_stall = 1'b0;
      prev_both  = 1'b0;
    end else begin
      check_eq("count_model", fifo_count, exp_q.size());
      if (prev_stall && mst_valid) begin
        stall_cmp++;
        check_eq("stall_hold", {mst_last, mst_mode, mst_proc_val, mst_data}, prev_beat);
      end
      if (prev_both) check_eq("push_pop_count", fifo_count, prev_count);
      prev_both  = mst_valid && mst_ready && slvx_data_valid;
      prev_count = fifo_count;
      if (mst_valid && mst_ready) begin
        beat_idx++;
        beat_total++;
        check_eq("beat_available", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          check_eq("beat_data", {mst_mode, mst_proc_val, mst_data}, exp_q.pop_front());
        if (mst_last) begin
          last_idx = beat_idx;
          last_cyc = cyc;
        end
      end
      if (burst_done) begin
        done_cnt++;
        done_cyc = cyc;
        beat_idx = 0;
      end
      prev_stall = mst_valid && !mst_ready;
      prev_beat  = {mst_last, mst_mode, mst_proc_val, mst_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input bit accept);
    logic [41:0] w;
    w = word(id);
    slvx_data_valid = 1'b1;
    {slvx_mode, slvx_proc_val, slvx_data} = w;
    tick();
    slvx_data_valid = 1'b0;
    if (accept) exp_q.push_back(w);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    slvx_data_valid = 1'b0;
    flush = 1'b0;
    repeat (n) tick();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int target, input int limit);
    for (int k = 0; k < limit && done_cnt < target; k++) tick();
    check_eq(tag, done_cnt, target);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    int d0;
    int b0;
    rst_n = 1'b0;
    slvx_data_valid = 1'b0;
    slvx_mode = 2'd0;
    slvx_proc_val = 8'd0;
    slvx_data = 32'd0;
    flush = 1'b0;
    mst_ready = 1'b0;

    // 1. Reset while writing
    slvx_data_valid = 1'b1;
    {slvx_mode, slvx_proc_val, slvx_data} = word(99);
    tick();
    tick();
    @(negedge clk);
    check_eq("rst_count", fifo_count, 0);
    check_eq("rst_valid", mst_valid, 0);
    check_eq("rst_full", fifo_full, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_done", burst_done, 0);
    do_reset(1);
    tick();
    check_eq("rst_nostore", fifo_count, 0);

    // 2. Burst release
    mst_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(i, 1'b1);
    @(negedge clk);
    check_eq("b2_count4", fifo_count, 4);
    check_eq("b2_valid_low", mst_valid, 0);
    tick();
    check_eq("b2_valid_up", mst_valid, 1);
    wait_done("b2_done", 1, 20);
    check_eq("b2_last_beat", last_idx, 4);
    check_eq("b2_done_lat", done_cyc - last_cyc, 1);
    repeat (3) tick();
    check_eq("b2_one_pulse", done_cnt, 1);
    check_eq("b2_empty", fifo_count, 0);
    check_eq("b2_beats", beat_total, 4);

    // 3. Back-pressure and overflow
    do_reset(2);
    mst_ready = 1'b0;
    for (int i = 0; i < 13; i++) push(10 + i, 1'b1);
    check_eq("bp_full13", fifo_full, 0);
    push(23, 1'b1);
    check_eq("bp_count14", fifo_count, 14);
    check_eq("bp_full14", fifo_full, 1);
    push(24, 1'b1);
    push(25, 1'b1);
    check_eq("bp_count16", fifo_count, 16);
    check_eq("bp_noovf", overflow, 0);
    push(26, 1'b0);
    check_eq("bp_drop_count", fifo_count, 16);
    check_eq("bp_ovf", overflow, 1);
    repeat (3) tick();
    check_eq("bp_ovf_sticky", overflow, 1);
    d0 = done_cnt;
    mst_ready = 1'b1;
    wait_done("bp_drain", d0 + 4, 100);
    check_eq("bp_drained", fifo_count, 0);
    check_eq("bp_ovf_hold", overflow, 1);

    // 4. Flush partial burst, then flush when empty
    do_reset(2);
    check_eq("fl_ovf_clr", overflow, 0);
    mst_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(40 + i, 1'b1);
    repeat (4) tick();
    check_eq("fl_no_burst", mst_valid, 0);
    d0 = done_cnt;
    pulse_flush();
    wait_done("fl_done", d0 + 1, 20);
    check_eq("fl_last_beat", last_idx, 3);
    check_eq("fl_empty", fifo_count, 0);
    d0 = done_cnt;
    b0 = beat_total;
    pulse_flush();
    repeat (8) tick();
    check_eq("fl_empty_nodone", done_cnt, d0);
    check_eq("fl_empty_nobeat", beat_total, b0);

    // 5. Stalls with concurrent pushes across pointer wrap
    do_reset(2);
    for (int i = 0; i < 22; i++) begin
      mst_ready = (i % 2 == 0);
      push(60 + i, 1'b1);
    end
    for (int i = 22; i < 70; i++) begin
      mst_ready = (i % 2 == 0);
      tick();
    end
    pulse_flush();
    for (int i = 0; i < 30; i++) begin
      mst_ready = (i % 2 == 0);
      tick();
    end
    check_eq("st_drained_q", exp_q.size(), 0);
    check_eq("st_drained", fifo_count, 0);
    check_eq("st_stalls_seen", stall_cmp > 0, 1);

    // 6. Reset in the middle of a burst
    do_reset(2);
    mst_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(90 + i, 1'b1);
    for (int k = 0; k < 20 && beat_idx < 2; k++) tick();
    check_eq("mr_beat2", beat_idx, 2);
    d0 = done_cnt;
    mst_ready = 1'b0;
    do_reset(2);
    repeat (5) tick();
    check_eq("mr_nodone", done_cnt, d0);
    check_eq("mr_valid", mst_valid, 0);
    check_eq("mr_last", mst_last, 0);
    check_eq("mr_count", fifo_count, 0);
    check_eq("mr_full", fifo_full, 0);
    check_eq("mr_ovf", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
